// File: rtl/draw_arbiter.sv
// draw_arbiter: round-robin arbiter that gives one of three rectangle drawers
// (0 = brick loader, 1 = ball, 2 = platform) ownership of a single VGA plot port.
// The winner's rectangle is then rasterised one pixel per cycle.
//
// Ports
//   clk, resetn        rising-edge clock, synchronous active-low reset
//   req[2:0]           per-requester draw request
//   x0..y2, c0..c2     per-requester top-left corner (10 bit) and colour (3 bit)
//   grant[2:0]         one-hot owner of the plot port (LATCH/DRAW/DONE)
//   done[2:0]          one-hot, one-cycle completion pulse
//   plot               VGA write enable
//   x_out, y_out       pixel coordinate (wraps mod 1024)
//   colour_out         pixel colour
//   busy               high whenever the FSM is not idle
module draw_arbiter #(
    parameter int unsigned BRICK_W = 4,
    parameter int unsigned BRICK_H = 2,
    parameter int unsigned BALL_W  = 2,
    parameter int unsigned BALL_H  = 2,
    parameter int unsigned PLAT_W  = 20,
    parameter int unsigned PLAT_H  = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] req,
    input  logic [9:0] x0,
    input  logic [9:0] y0,
    input  logic [9:0] x1,
    input  logic [9:0] y1,
    input  logic [9:0] x2,
    input  logic [9:0] y2,
    input  logic [2:0] c0,
    input  logic [2:0] c1,
    input  logic [2:0] c2,
    output logic [2:0] grant,
    output logic [2:0] done,
    output logic       plot,
    output logic [9:0] x_out,
    output logic [9:0] y_out,
    output logic [2:0] colour_out,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_DRAW, S_DONE} state_t;

    // Sizes are 1..32, so 6 bits hold both the size and the counters.
    localparam logic [5:0] BrickW = 6'(BRICK_W);
    localparam logic [5:0] BrickH = 6'(BRICK_H);
    localparam logic [5:0] BallW  = 6'(BALL_W);
    localparam logic [5:0] BallH  = 6'(BALL_H);
    localparam logic [5:0] PlatW  = 6'(PLAT_W);
    localparam logic [5:0] PlatH  = 6'(PLAT_H);

    state_t     r_state, w_state_d;
    logic [1:0] r_ptr, r_g, w_winner;
    logic [9:0] r_bx, r_by;
    logic [2:0] r_col;
    logic [5:0] r_w, r_h, r_cx, r_cy;

    logic [9:0] w_sel_x, w_sel_y;
    logic [2:0] w_sel_c;
    logic [5:0] w_sel_w, w_sel_h;
    logic       w_last_x, w_last_y;
    logic [2:0] w_onehot;

    // Round-robin: scan ptr+1, ptr+2, ptr+3 (mod 3) for the first pending request.
    always_comb begin
        w_winner = 2'd0;
        case (r_ptr)
            2'd0:    w_winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    w_winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: w_winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        w_sel_x = x0;
        w_sel_y = y0;
        w_sel_c = c0;
        w_sel_w = BrickW;
        w_sel_h = BrickH;
        case (w_winner)
            2'd1: begin
                w_sel_x = x1;
                w_sel_y = y1;
                w_sel_c = c1;
                w_sel_w = BallW;
                w_sel_h = BallH;
            end
            2'd2: begin
                w_sel_x = x2;
                w_sel_y = y2;
                w_sel_c = c2;
                w_sel_w = PlatW;
                w_sel_h = PlatH;
            end
            default: ;
        endcase
    end

    assign w_last_x = (r_cx == r_w - 6'd1);
    assign w_last_y = (r_cy == r_h - 6'd1);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_IDLE:  if (req != 3'b000) w_state_d = S_LATCH;
            S_LATCH: w_state_d = S_DRAW;
            S_DRAW:  if (w_last_x && w_last_y) w_state_d = S_DONE;
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd2;
            r_g     <= 2'd0;
            r_bx    <= '0;
            r_by    <= '0;
            r_col   <= '0;
            r_w     <= 6'd1;
            r_h     <= 6'd1;
            r_cx    <= '0;
            r_cy    <= '0;
        end else begin
            r_state <= w_state_d;
            case (r_state)
                S_IDLE: begin
                    // Operands are taken at the decision edge so that anything
                    // the requester changes from S_LATCH onwards has no effect.
                    if (req != 3'b000) begin
                        r_g   <= w_winner;
                        r_bx  <= w_sel_x;
                        r_by  <= w_sel_y;
                        r_col <= w_sel_c;
                        r_w   <= w_sel_w;
                        r_h   <= w_sel_h;
                    end
                end
                S_LATCH: begin
                    r_cx <= '0;
                    r_cy <= '0;
                end
                S_DRAW: begin
                    if (w_last_x) begin
                        r_cx <= '0;
                        r_cy <= r_cy + 6'd1;
                    end else begin
                        r_cx <= r_cx + 6'd1;
                    end
                end
                S_DONE:  r_ptr <= r_g;
                default: ;
            endcase
        end
    end

    assign w_onehot = 3'b001 << r_g;

    always_comb begin
        grant      = '0;
        done       = '0;
        plot       = 1'b0;
        x_out      = '0;
        y_out      = '0;
        colour_out = '0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_LATCH: grant = w_onehot;
            S_DRAW: begin
                grant      = w_onehot;
                plot       = 1'b1;
                x_out      = r_bx + {4'b0000, r_cx};
                y_out      = r_by + {4'b0000, r_cy};
                colour_out = r_col;
            end
            S_DONE: begin
                grant = w_onehot;
                done  = w_onehot;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_draw_arbiter.sv
// Self-checking bench for draw_arbiter: a table of transactions (request pattern,
// expected winner and rectangle) plus hand-written reset-abort, input-stability
// and 1x1 sequences.
module tb_draw_arbiter;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] req, req1;
    logic [9:0] x0, y0, x1, y1, x2, y2;
    logic [2:0] c0, c1, c2;
    logic [2:0] grant, done, colour_out;
    logic       plot, busy;
    logic [9:0] x_out, y_out;

    logic [2:0] d1_grant, d1_done, d1_colour;
    logic       d1_plot, d1_busy;
    logic [9:0] d1_x, d1_y;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    draw_arbiter u_dut (
        .clk(clk), .resetn(resetn), .req(req),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .c0(c0), .c1(c1), .c2(c2),
        .grant(grant), .done(done), .plot(plot), .x_out(x_out), .y_out(y_out),
        .colour_out(colour_out), .busy(busy)
    );

    // All rectangles 1x1.
    draw_arbiter #(
        .BRICK_W(1), .BRICK_H(1), .BALL_W(1), .BALL_H(1), .PLAT_W(1), .PLAT_H(1)
    ) u_dut1 (
        .clk(clk), .resetn(resetn), .req(req1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .c0(c0), .c1(c1), .c2(c2),
        .grant(d1_grant), .done(d1_done), .plot(d1_plot), .x_out(d1_x), .y_out(d1_y),
        .colour_out(d1_colour), .busy(d1_busy)
    );

    typedef struct {
        logic [2:0] req;
        int         g;
        int         bx;
        int         by;
        int         col;
        int         w;
        int         h;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // Full transaction from the idle decision cycle back to idle.
    task automatic run_txn(input logic [2:0] r, input int g, input int bx, input int by,
                           input int col, input int w, input int h, input bit perturb);
        int ex, ey;
        req = r;
        chk("idle_busy", int'(busy), 0);
        chk("idle_grant", int'(grant), 0);
        tick();
        chk("latch_grant", int'(grant), 1 << g);
        chk("latch_busy", int'(busy), 1);
        chk("latch_plot", int'(plot), 0);
        tick();
        for (int k = 0; k < w * h; k++) begin
            ex = (bx + k % w) % 1024;
            ey = (by + k / w) % 1024;
            chk("draw_plot", int'(plot), 1);
            chk("draw_x", int'(x_out), ex);
            chk("draw_y", int'(y_out), ey);
            chk("draw_colour", int'(colour_out), col);
            chk("draw_grant", int'(grant), 1 << g);
            chk("draw_done", int'(done), 0);
            if (perturb && k == 0) begin
                x1  = 10'd500;
                y1  = 10'd600;
                c1  = 3'd7;
                req = 3'b000;
            end
            tick();
        end
        chk("done_pulse", int'(done), 1 << g);
        chk("done_plot", int'(plot), 0);
        chk("done_grant", int'(grant), 1 << g);
        req = r & ~(3'b001 << g);
        tick();
        chk("post_done", int'(done), 0);
        chk("post_busy", int'(busy), 0);
        chk("post_grant", int'(grant), 0);
    endtask

    initial begin
        resetn = 1'b0;
        req    = 3'b000;
        req1   = 3'b000;
        x0 = 10'd40;   y0 = 10'd8;    c0 = 3'd5;
        x1 = 10'd100;  y1 = 10'd200;  c1 = 3'd3;
        x2 = 10'd1015; y2 = 10'd1023; c2 = 3'd6;

        vecs[0] = '{3'b001, 0, 40, 8, 5, 4, 2};       // single brick
        vecs[1] = '{3'b100, 2, 1015, 1023, 6, 20, 1}; // platform wraps in x
        vecs[2] = '{3'b111, 0, 40, 8, 5, 4, 2};       // contention, ptr=2
        vecs[3] = '{3'b110, 1, 100, 200, 3, 2, 2};
        vecs[4] = '{3'b100, 2, 1015, 1023, 6, 20, 1};
        vecs[5] = '{3'b011, 0, 40, 8, 5, 4, 2};       // re-request 0,1 after ptr=2
        vecs[6] = '{3'b011, 1, 100, 200, 3, 2, 2};    // fairness alternation
        vecs[7] = '{3'b011, 0, 40, 8, 5, 4, 2};
        vecs[8] = '{3'b011, 1, 100, 200, 3, 2, 2};

        tick();
        tick();
        chk("rst_grant", int'(grant), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_x", int'(x_out), 0);
        chk("rst_y", int'(y_out), 0);
        chk("rst_colour", int'(colour_out), 0);
        chk("rst_busy", int'(busy), 0);
        resetn = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_txn(vecs[i].req, vecs[i].g, vecs[i].bx, vecs[i].by, vecs[i].col,
                    vecs[i].w, vecs[i].h, 1'b0);
        end

        // Reset during the 3rd plot of a platform draw (ptr=1 beforehand).
        req = 3'b100;
        tick();
        chk("abort_grant", int'(grant), 4);
        tick();
        tick();
        tick();
        chk("abort_plot3_x", int'(x_out), 1017);
        resetn = 1'b0;
        tick();
        chk("abort_grant0", int'(grant), 0);
        chk("abort_done0", int'(done), 0);
        chk("abort_plot0", int'(plot), 0);
        chk("abort_x0", int'(x_out), 0);
        chk("abort_y0", int'(y_out), 0);
        chk("abort_colour0", int'(colour_out), 0);
        chk("abort_busy0", int'(busy), 0);
        resetn = 1'b1;
        // ptr back at 2: ball beats platform.
        run_txn(3'b110, 1, 100, 200, 3, 2, 2, 1'b0);

        // Ball inputs change mid-draw; pixels must keep the latched values.
        run_txn(3'b010, 1, 100, 200, 3, 2, 2, 1'b1);
        x1 = 10'd100; y1 = 10'd200; c1 = 3'd3;

        // 1x1 rectangle: exactly one plot cycle.
        req1 = 3'b001;
        tick();
        chk("one_latch_plot", int'(d1_plot), 0);
        chk("one_latch_grant", int'(d1_grant), 1);
        tick();
        chk("one_plot", int'(d1_plot), 1);
        chk("one_x", int'(d1_x), 40);
        chk("one_y", int'(d1_y), 8);
        chk("one_colour", int'(d1_colour), 5);
        tick();
        chk("one_done", int'(d1_done), 1);
        chk("one_done_plot", int'(d1_plot), 0);
        req1 = 3'b000;
        tick();
        chk("one_idle_busy", int'(d1_busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
